pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage MIPS pipeline. It generates hold and bubble controls for the IF/ID and ID/EX stage registers. It covers three hazards:
- load-use data hazards
- taken-branch redirects resolved in EX
- structural/data hazards on HI/LO while the multi-cycle MULT/DIV unit is busy

It owns the MULT/DIV sequencing FSM, which produces the one-cycle HI/LO write strobe that accompanies the result into the MEM/WB path. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MULT_CYCLES, 4, busy cycles for MULT/MULTU (must be 1..255)
DIV_CYCLES, 32, busy cycles for DIV/DIVU (must be 1..255)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  pipeline clock
rstN  in  1  asynchronous active-low reset
idRs  in  5  rs field of the instruction in ID
idRt  in  5  rt field of the instruction in ID
idUsesRs  in  1  ID instruction reads rs
idUsesRt  in  1  ID instruction reads rt
idReadsLoHi  in  1  ID instruction is MFHI/MFLO
idIsMulDiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
exMemRead  in  1  EX instruction is a load
exWriteReg  in  5  destination register of the EX instruction
exMulDivStart  in  1  EX instruction is MULT/DIV (start request)
exIsDiv  in  1  qualifies exMulDivStart: 1 = divide, 0 = multiply
exBranchTaken  in  1  EX resolved a taken branch/jump
stallIF  out  1  hold PC
stallID  out  1  hold IF/ID register
flushID  out  1  squash IF/ID (load NOP)
flushEX  out  1  insert bubble into ID/EX
mdBusy  out  1  MULT/DIV unit iterating
mdDone  out  1  one-cycle HI/LO write strobe
stallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- All state (FSM, iteration counter, stallCount) updates on the falling edge of clk, the same edge as the stage registers.
- rstN low immediately sets state=IDLE, iteration count=0 and stallCount=0, and forces every output to 0, including the combinational ones.
- Reset mid-operation aborts the MULT/DIV with no mdDone.
- Load-use hazard: loadUse = exMemRead & (exWriteReg!=0) & ((idUsesRs & idRs==exWriteReg) | (idUsesRt & idRt==exWriteReg)).
- HI/LO hazard: mdHaz = (idReadsLoHi | idIsMulDiv) & (state==BUSY | (state!=BUSY & exMulDivStart)).
- Outputs stallIF, stallID, flushID and flushEX are combinational from the inputs and state. Priority:
  - exBranchTaken=1: flushID=1, flushEX=1, stallIF=stallID=0. The redirect wins over any stall.
  - else if loadUse|mdHaz: stallIF=stallID=1, flushEX=1, flushID=0.
  - else: all 0.
- MULT/DIV FSM states:
  - IDLE: exMulDivStart moves to BUSY and loads cnt = (exIsDiv ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: mdBusy=1. If cnt==0 move to DONE, else cnt--. exMulDivStart is ignored here; the mdHaz stall guarantees it cannot legally occur.
  - DONE: mdDone=1 for exactly one cycle. exMulDivStart here moves straight back to BUSY with a fresh load (back-to-back). Otherwise return to IDLE.
- Latency: a start sampled at edge t gives mdBusy high for exactly N cycles, and mdDone high in the single cycle that follows. N=MULT_CYCLES or DIV_CYCLES.
- DONE does not stall: an MFHI in ID during DONE proceeds. HI/LO forwarding is not this block's job.
- exBranchTaken does not cancel an in-flight MULT/DIV. The operation is older than the branch.
- stallCount increments on every edge where stallIF=1 and saturates at all-ones. A flush-only cycle does not count.

Test Plan:
- Load-use: exMemRead=1, exWriteReg=8, idRs=8, idUsesRs=1 -> stallIF=stallID=flushEX=1 for one cycle, stallCount 0->1. Repeat with exWriteReg=0 -> no stall.
- MULT latency: exMulDivStart=1, exIsDiv=0 at edge t -> mdBusy high for 4 cycles, mdDone high in the 5th cycle only, then IDLE. DIV gives 32 busy cycles.
- HI/LO stall: MFHI in ID during DIV BUSY -> stallIF=stallID=flushEX=1 every BUSY cycle, released in the DONE cycle. stallCount advances by the number of stalled cycles.
- Branch priority: exBranchTaken=1 together with a load-use condition -> flushID=flushEX=1, stallIF=0, stallCount unchanged.
- Back-to-back: exMulDivStart asserted in the DONE cycle -> BUSY re-entered next cycle with a fresh count, with no IDLE gap.
- Async reset: drop rstN in BUSY at count 10 -> all outputs 0 immediately, no mdDone after release. After release, a new MULT completes in exactly 4 busy cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use, branch redirect and
// HI/LO hazards, plus the MULT/DIV sequencing FSM and a stall performance counter.
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRs,
    input  logic             idUsesRt,
    input  logic             idReadsLoHi,
    input  logic             idIsMulDiv,
    input  logic             exMemRead,
    input  logic [4:0]       exWriteReg,
    input  logic             exMulDivStart,
    input  logic             exIsDiv,
    input  logic             exBranchTaken,
    output logic             stallIF,
    output logic             stallID,
    output logic             flushID,
    output logic             flushEX,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mdState_t;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    mdState_t   state;
    mdState_t   nextState;
    logic [7:0] cnt;
    logic [7:0] nextCnt;
    logic       loadUse;
    logic       mdHaz;

    assign loadUse = exMemRead && (exWriteReg != 5'd0) &&
                     ((idUsesRs && (idRs == exWriteReg)) ||
                      (idUsesRt && (idRt == exWriteReg)));

    // A start arriving in EX also blocks HI/LO users, since the unit is about to go busy.
    assign mdHaz = (idReadsLoHi || idIsMulDiv) &&
                   ((state == BUSY) || exMulDivStart);

    always_comb begin
        stallIF = 1'b0;
        stallID = 1'b0;
        flushID = 1'b0;
        flushEX = 1'b0;
        if (rstN) begin
            if (exBranchTaken) begin
                flushID = 1'b1;
                flushEX = 1'b1;
            end else if (loadUse || mdHaz) begin
                stallIF = 1'b1;
                stallID = 1'b1;
                flushEX = 1'b1;
            end
        end
    end

    assign mdBusy = rstN && (state == BUSY);
    assign mdDone = rstN && (state == DONE);

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE, DONE: begin
                if (exMulDivStart) begin
                    nextState = BUSY;
                    nextCnt   = exIsDiv ? DIV_LOAD : MULT_LOAD;
                end else begin
                    nextState = IDLE;
                end
            end
            BUSY: begin
                if (cnt == 8'd0) begin
                    nextState = DONE;
                end else begin
                    nextCnt = cnt - 8'd1;
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = 8'd0;
            end
        endcase
    end

    // State advances on the falling edge, together with the pipeline stage registers.
    always_ff @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            stallCount <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (stallIF && (stallCount != {CNT_W{1'b1}})) begin
                stallCount <= stallCount + CNT_W'(1);
            end
        end
    end

endmodule
